// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the framed UART transmitter.
package uart_tx_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    function automatic int nwords(input int data_w, input int word_w);
        return (data_w + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: tick_out marks the last clk_in cycle of each serial bit.
module tx_bit_timer
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic clear_in,
    output logic tick_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_out = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_in || tick_out) begin
            cnt_d = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Latches a wide payload and streams it out as a sequence of UART-framed words.
module uart_frame_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 162,
    parameter int WORD_W       = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              trigger_in,
    input  logic              abort_in,
    input  logic [DATA_W-1:0] val_in,
    output logic              data_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int NWORDS = nwords(DATA_W, WORD_W);
    localparam int PAY_W  = NWORDS * WORD_W;
    localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int BIDX_W = $clog2(WORD_W) + 1;

    tx_state_e         state_q, state_d;
    logic [PAY_W-1:0]  payload_q, payload_d;
    logic [WIDX_W-1:0] word_q, word_d;
    logic [BIDX_W-1:0] bit_q, bit_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic              tick;
    logic [PAY_W-1:0]  word_shift;
    logic [WORD_W-1:0] cur_word;
    logic [WORD_W-1:0] bit_shift;

    // The timer is held in reset while idle, so every frame starts on a fresh bit period.
    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk_in  (clk_in),
        .rst_n_in(rst_n_in),
        .clear_in(state_q == IDLE),
        .tick_out(tick)
    );

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        state_d   = state_q;
        payload_d = payload_q;
        word_d    = word_q;
        bit_d     = bit_q;
        done_d    = 1'b0;

        if (state_q == IDLE) begin
            if (trigger_in) begin
                payload_d = PAY_W'(val_in);
                word_d    = '0;
                bit_d     = '0;
                state_d   = START;
            end
        end else if (abort_in) begin
            state_d = IDLE;
        end else if (tick) begin
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    if (bit_q == BIDX_W'(WORD_W - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + BIDX_W'(1);
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    bit_d   = '0;
                end
                STOP: begin
                    if (bit_q == BIDX_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (word_q == WIDX_W'(NWORDS - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = START;
                            word_d  = word_q + WIDX_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Line level is registered from the next state so the serial pin is glitch-free.
    always_comb begin
        word_shift = payload_d >> (int'(word_d) * WORD_W);
        cur_word   = word_shift[WORD_W-1:0];
        bit_shift  = cur_word >> bit_d;
        line_d     = 1'b1;
        unique case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = bit_shift[0];
            PARITY:  line_d = (^cur_word) ^ (PARITY_ODD != 0);
            default: line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            payload_q <= '0;
            word_q    <= '0;
            bit_q     <= '0;
            line_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            word_q    <= word_d;
            bit_q     <= bit_d;
            line_q    <= line_d;
            done_q    <= done_d;
        end
    end

    assign data_out = line_q;
    assign busy_out = (state_q != IDLE);
    assign done_out = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench: three configurations driven with directed and random frames.
module tb_uart_frame_tx;

    localparam int CPB      = 4;
    localparam int M_NORM   = 0;
    localparam int M_RETRIG = 1;
    localparam int M_ABORT  = 2;
    localparam int M_ABTRIG = 3;
    localparam int M_RESET  = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   trig;
    logic [2:0]   abrt;
    logic [161:0] val_bus;
    logic [2:0]   line_o, busy_o, done_o;

    int sel;
    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    int dw_c[3] = '{16, 162, 8};
    int pe_c[3] = '{0, 0, 1};
    int po_c[3] = '{0, 0, 0};
    int sb_c[3] = '{1, 1, 2};

    always #5 clk = ~clk;

    uart_frame_tx #(.DATA_W(16), .WORD_W(8), .CLKS_PER_BIT(CPB)) u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig[0]), .abort_in(abrt[0]),
        .val_in(val_bus[15:0]), .data_out(line_o[0]), .busy_out(busy_o[0]), .done_out(done_o[0])
    );

    uart_frame_tx #(.CLKS_PER_BIT(CPB)) u_def (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig[1]), .abort_in(abrt[1]),
        .val_in(val_bus), .data_out(line_o[1]), .busy_out(busy_o[1]), .done_out(done_o[1])
    );

    uart_frame_tx #(.DATA_W(8), .WORD_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1),
                    .PARITY_ODD(0), .STOP_BITS(2)) u_par (
        .clk_in(clk), .rst_n_in(rst_n), .trigger_in(trig[2]), .abort_in(abrt[2]),
        .val_in(val_bus[7:0]), .data_out(line_o[2]), .busy_out(busy_o[2]), .done_out(done_o[2])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the serial line as a list of bit values, one entry per bit period.
    function automatic void build(input logic [161:0] v, input int s);
        int nw;
        bit par;
        bit b;
        exp_q.delete();
        nw = (dw_c[s] + 7) / 8;
        for (int k = 0; k < nw; k++) begin
            exp_q.push_back(1'b0);
            par = 1'b0;
            for (int i = 0; i < 8; i++) begin
                b = (k * 8 + i < dw_c[s]) ? v[k * 8 + i] : 1'b0;
                exp_q.push_back(b);
                par ^= b;
            end
            if (pe_c[s] != 0) exp_q.push_back(par ^ (po_c[s] != 0));
            for (int j = 0; j < sb_c[s]; j++) exp_q.push_back(1'b1);
        end
    endfunction

    function automatic logic [161:0] rand_val();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[161:0];
    endfunction

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_idle_line"}, line_o[sel], 1'b1);
            check({tag, "_idle_busy"}, busy_o[sel], 1'b0);
            check({tag, "_idle_done"}, done_o[sel], 1'b0);
            step();
        end
    endtask

    task automatic launch(input int s, input logic [161:0] v);
        sel     = s;
        val_bus = v;
        build(v, s);
        trig[s] = 1'b1;
        step();
        trig[s] = 1'b0;
    endtask

    // Walks the expected line cycle by cycle; normal frames end on the done_out cycle.
    task automatic run_frame(input string tag, input int mode, input int at);
        for (int c = 0; c < exp_q.size() * CPB; c++) begin
            check({tag, "_line"}, line_o[sel], exp_q[c / CPB]);
            check({tag, "_busy"}, busy_o[sel], 1'b1);
            check({tag, "_done"}, done_o[sel], 1'b0);
            if (c == at) begin
                case (mode)
                    M_RETRIG: begin
                        trig[sel] = 1'b1;
                        val_bus   = ~val_bus;
                    end
                    M_ABORT:  abrt[sel] = 1'b1;
                    M_ABTRIG: begin
                        abrt[sel] = 1'b1;
                        trig[sel] = 1'b1;
                    end
                    M_RESET: begin
                        #3;
                        rst_n = 1'b0;
                        #1;
                        check({tag, "_async_line"}, line_o[sel], 1'b1);
                        check({tag, "_async_busy"}, busy_o[sel], 1'b0);
                        check({tag, "_async_done"}, done_o[sel], 1'b0);
                        step();
                        rst_n = 1'b1;
                        idle_cycles(tag, 6);
                        return;
                    end
                    default: ;
                endcase
            end
            step();
            if (c == at && mode == M_RETRIG) trig[sel] = 1'b0;
            if (c == at && (mode == M_ABORT || mode == M_ABTRIG)) begin
                trig[sel] = 1'b0;
                abrt[sel] = 1'b0;
                idle_cycles(tag, 5);
                return;
            end
        end
        check({tag, "_end_line"}, line_o[sel], 1'b1);
        check({tag, "_end_busy"}, busy_o[sel], 1'b0);
        check({tag, "_end_done"}, done_o[sel], 1'b1);
    endtask

    initial begin
        logic [161:0] v;
        trig    = '0;
        abrt    = '0;
        val_bus = '0;
        sel     = 0;

        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            check("reset_line", line_o[s], 1'b1);
            check("reset_busy", busy_o[s], 1'b0);
            check("reset_done", done_o[s], 1'b0);
        end
        rst_n = 1'b1;
        step();

        // Two-word frame 0xA55A.
        launch(0, 162'hA55A);
        run_frame("t1", M_NORM, -1);
        step();
        idle_cycles("t1", 3);

        // Full 162-bit payload with zero-padded last word.
        launch(1, {2'b10, {40{4'hA}}});
        run_frame("t2", M_NORM, -1);
        step();
        idle_cycles("t2", 2);

        // Even parity, two stop bits.
        launch(2, 162'h07);
        run_frame("t3", M_NORM, -1);
        step();
        idle_cycles("t3", 2);

        for (int n = 0; n < 6; n++) begin
            launch(n % 3, rand_val());
            run_frame("rand", M_NORM, -1);
            step();
            idle_cycles("rand", 1);
        end

        // Retrigger while busy is ignored; retrigger on done starts the next frame at once.
        launch(0, rand_val());
        run_frame("retrig", M_RETRIG, 30);
        step();
        idle_cycles("retrig", 3);
        launch(0, rand_val());
        run_frame("b2b_a", M_NORM, -1);
        v       = rand_val();
        val_bus = v;
        build(v, 0);
        trig[0] = 1'b1;
        step();
        trig[0] = 1'b0;
        run_frame("b2b_b", M_NORM, -1);
        step();
        idle_cycles("b2b", 2);

        // Abort in the middle of word 3, then a complete frame.
        launch(1, rand_val());
        run_frame("abort", M_ABORT, 3 * 10 * CPB + 17);
        launch(1, rand_val());
        run_frame("post_abort", M_NORM, -1);
        step();
        idle_cycles("post_abort", 1);

        // Abort together with trigger while busy: abort wins.
        launch(2, rand_val());
        run_frame("abtrig", M_ABTRIG, 21);

        // Abort alone in idle does nothing; with trigger in idle the trigger wins.
        sel     = 0;
        abrt[0] = 1'b1;
        step();
        abrt[0] = 1'b0;
        idle_cycles("abort_idle", 2);
        v       = rand_val();
        val_bus = v;
        build(v, 0);
        abrt[0] = 1'b1;
        trig[0] = 1'b1;
        step();
        abrt[0] = 1'b0;
        trig[0] = 1'b0;
        run_frame("abtrig_idle", M_NORM, -1);
        step();

        // Asynchronous reset in the middle of a data bit.
        launch(0, rand_val());
        run_frame("rst", M_RESET, 3 * CPB + 2);
        launch(0, rand_val());
        run_frame("post_rst", M_NORM, -1);
        step();
        idle_cycles("post_rst", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
